spi_param_loader: RTL and testbench

- SPI slave that receives host parameter writes and turns them into single-cycle writes on the 1024x18 user parameter memory (phase increments, envelope words).
- The FM voice dispatcher/synthesis stage reads that memory; this block is its direct upstream feeder.
- Runs entirely in the IO_main_clk domain: SCK, CS and MOSI are oversampled through synchronisers, and there is no SPI clock domain.

---
 rtl/spi_param_loader_if.sv | 40 ++++
 rtl/spi_param_loader.sv | 187 ++++++++++++++++++
 tb/tb_spi_param_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_param_loader_if.sv
// SPI pin and user-memory write bundle for spi_param_loader.
// IO_SPI_miso exists only when SPI_MISO_EN is defined.
interface spi_param_loader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 18
);
    logic              IO_SPI_cs;
    logic              IO_SPI_sck;
    logic              IO_SPI_mosi;
`ifdef SPI_MISO_EN
    logic              IO_SPI_miso;
`endif
    logic              IO_User_Mem_w_en;
    logic [ADDR_W-1:0] IO_User_Mem_w_addr;
    logic [DATA_W-1:0] IO_User_Mem_w_value;

    modport slave (
        input  IO_SPI_cs,
        input  IO_SPI_sck,
        input  IO_SPI_mosi,
`ifdef SPI_MISO_EN
        output IO_SPI_miso,
`endif
        output IO_User_Mem_w_en,
        output IO_User_Mem_w_addr,
        output IO_User_Mem_w_value
    );

    modport master (
        output IO_SPI_cs,
        output IO_SPI_sck,
        output IO_SPI_mosi,
`ifdef SPI_MISO_EN
        input  IO_SPI_miso,
`endif
        input  IO_User_Mem_w_en,
        input  IO_User_Mem_w_addr,
        input  IO_User_Mem_w_value
    );
endinterface

// File: rtl/spi_param_loader.sv
// Oversampled SPI slave turning burst parameter writes into single-cycle user-memory writes.
// Optional MISO link-test echo enabled by defining SPI_MISO_EN.
module spi_param_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned WORD_BITS = 24,
    parameter logic [7:0]  CMD_WRITE = 8'h01
) (
    input  logic              IO_main_clk,
    input  logic              IO_rst_n,
    spi_param_loader_if.slave bus,
    output logic              frame_err,
    output logic              busy
);
    localparam int unsigned CNT_W   = $clog2(WORD_BITS + 1);
    localparam int unsigned SHIFT_W = (DATA_W > 16) ? DATA_W : 16;
    localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(WORD_BITS - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDiscard} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [1:0]          r_cs_sync, r_sck_sync, r_mosi_sync;
    logic                r_cs_prev, r_sck_prev;
    logic [1:0]          r_flush;
    logic                r_armed;
    logic [CNT_W-1:0]    r_cnt;
    logic [SHIFT_W-1:0]  r_shift;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_w_en;
    logic [ADDR_W-1:0]   r_w_addr;
    logic [DATA_W-1:0]   r_w_value;
    logic                r_frame_err;

    logic               w_cs_s, w_sck_s, w_mosi_s;
    logic               w_cs_fall, w_cs_rise, w_sck_rise;
    logic [SHIFT_W-1:0] w_shift_next;
    logic               w_clr, w_take, w_cnt_clr, w_err_set, w_addr_ld, w_word_done;
    logic               w_unused_shift_msb;

    assign w_cs_s       = r_cs_sync[1];
    assign w_sck_s      = r_sck_sync[1];
    assign w_mosi_s     = r_mosi_sync[1];
    // The synchroniser resets to cs=1, so a CS already low at reset must not look like a fall.
    assign w_cs_fall    = r_armed & r_cs_prev & ~w_cs_s;
    assign w_cs_rise    = ~r_cs_prev & w_cs_s;
    assign w_sck_rise   = ~r_sck_prev & w_sck_s;
    assign w_shift_next = {r_shift[SHIFT_W-2:0], w_mosi_s};
    assign w_unused_shift_msb = r_shift[SHIFT_W-1];

    always_ff @(posedge IO_main_clk) begin
        if (!IO_rst_n) r_state <= StIdle;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_take       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_err_set    = 1'b0;
        w_addr_ld    = 1'b0;
        w_word_done  = 1'b0;
        if (w_cs_fall) begin
            w_state_next = StCmd;
            w_clr        = 1'b1;
        end else if (w_cs_rise) begin
            w_state_next = StIdle;
            if ((r_state == StCmd || r_state == StAddr || r_state == StData) && r_cnt != '0) begin
                w_err_set = 1'b1;
            end
        end else if (w_sck_rise) begin
            case (r_state)
                StCmd: begin
                    w_take = 1'b1;
                    if (r_cnt == CNT_CMD_LAST) begin
                        w_cnt_clr = 1'b1;
                        if (w_shift_next[7:0] == CMD_WRITE) begin
                            w_state_next = StAddr;
                        end else begin
                            w_state_next = StDiscard;
                            w_err_set    = 1'b1;
                        end
                    end
                end
                StAddr: begin
                    w_take = 1'b1;
                    if (r_cnt == CNT_ADDR_LAST) begin
                        w_cnt_clr    = 1'b1;
                        w_addr_ld    = 1'b1;
                        w_state_next = StData;
                    end
                end
                StData: begin
                    w_take = 1'b1;
                    if (r_cnt == CNT_DATA_LAST) begin
                        w_cnt_clr   = 1'b1;
                        w_word_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge IO_main_clk) begin
        if (!IO_rst_n) begin
            r_cs_sync   <= 2'b11;
            r_sck_sync  <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_prev   <= 1'b1;
            r_sck_prev  <= 1'b0;
            r_flush     <= 2'b00;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_w_en      <= 1'b0;
            r_w_addr    <= '0;
            r_w_value   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], bus.IO_SPI_cs};
            r_sck_sync  <= {r_sck_sync[0], bus.IO_SPI_sck};
            r_mosi_sync <= {r_mosi_sync[0], bus.IO_SPI_mosi};
            r_cs_prev   <= w_cs_s;
            r_sck_prev  <= w_sck_s;
            r_flush     <= {r_flush[0], 1'b1};
            r_armed     <= r_armed | (r_flush[1] & w_cs_s);
            r_w_en      <= w_word_done;
            if (w_clr) begin
                r_frame_err <= 1'b0;
                r_cnt       <= '0;
                r_shift     <= '0;
            end else begin
                if (w_err_set) r_frame_err <= 1'b1;
                if (w_take) begin
                    r_shift <= w_shift_next;
                    r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
                end
            end
            if (w_addr_ld) r_addr <= w_shift_next[ADDR_W-1:0];
            if (w_word_done) begin
                r_w_addr  <= r_addr;
                r_w_value <= w_shift_next[DATA_W-1:0];
                r_addr    <= r_addr + 1'b1;
            end
        end
    end

`ifdef SPI_MISO_EN
    logic [7:0] r_echo;
    logic [7:0] r_miso_sr;
    logic       r_miso_load;
    logic       w_sck_fall;

    assign w_sck_fall = r_sck_prev & ~w_sck_s;

    // A completed byte is presented on the fall after its last rise, then shifted per fall.
    always_ff @(posedge IO_main_clk) begin
        if (!IO_rst_n) begin
            r_echo      <= '0;
            r_miso_sr   <= '0;
            r_miso_load <= 1'b0;
        end else if (w_cs_s) begin
            r_miso_sr   <= '0;
            r_miso_load <= 1'b0;
        end else if (w_take && r_cnt[2:0] == 3'd7) begin
            r_echo      <= w_shift_next[7:0];
            r_miso_load <= 1'b1;
        end else if (w_sck_fall) begin
            r_miso_sr   <= r_miso_load ? r_echo : {r_miso_sr[6:0], 1'b0};
            r_miso_load <= 1'b0;
        end
    end

    assign bus.IO_SPI_miso = r_miso_sr[7];
`endif

    assign bus.IO_User_Mem_w_en    = r_w_en;
    assign bus.IO_User_Mem_w_addr  = r_w_addr;
    assign bus.IO_User_Mem_w_value = r_w_value;
    assign frame_err               = r_frame_err;
    assign busy                    = (r_state != StIdle);
endmodule

// File: tb/tb_spi_param_loader.sv
// Scoreboard bench for spi_param_loader; covers the MISO echo when SPI_MISO_EN is defined.
module tb_spi_param_loader;
    localparam int H = 6;  // SCK half period in clocks

    logic clk = 1'b0;
    logic rst_n;
    logic frame_err;
    logic busy;

    spi_param_loader_if #(.ADDR_W(10), .DATA_W(18)) bus ();

    spi_param_loader #(
        .ADDR_W   (10),
        .DATA_W   (18),
        .WORD_BITS(24),
        .CMD_WRITE(8'h01)
    ) dut (
        .IO_main_clk(clk),
        .IO_rst_n   (rst_n),
        .bus        (bus),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          n_writes  = 0;
    int          n_pushed  = 0;
    logic [27:0] sb_q[$];
    logic        prev_wen  = 1'b0;
`ifdef SPI_MISO_EN
    logic [7:0]  miso_cap;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.IO_SPI_mosi = val[i];
            clks(H);
`ifdef SPI_MISO_EN
            miso_cap = {miso_cap[6:0], bus.IO_SPI_miso};
`endif
            bus.IO_SPI_sck = 1'b1;
            clks(H);
            bus.IO_SPI_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.IO_SPI_cs = 1'b0;
        clks(H);
    endtask

    task automatic cs_high();
        clks(H);
        bus.IO_SPI_cs = 1'b1;
        clks(8);
    endtask

    task automatic push_write(input logic [9:0] addr, input logic [17:0] value);
        sb_q.push_back({addr, value});
        n_pushed++;
    endtask

    task automatic check_idle_outputs(input string phase);
        check_eq({phase, "_wen"}, bus.IO_User_Mem_w_en, 0);
        check_eq({phase, "_waddr"}, bus.IO_User_Mem_w_addr, 0);
        check_eq({phase, "_wvalue"}, bus.IO_User_Mem_w_value, 0);
        check_eq({phase, "_frame_err"}, frame_err, 0);
        check_eq({phase, "_busy"}, busy, 0);
    endtask

    // Scoreboard consumer: every strobe must match the oldest pushed write.
    always @(negedge clk) begin
        if (rst_n && bus.IO_User_Mem_w_en) begin
            logic [27:0] exp_w;
            n_writes++;
            check_eq("wen_single_cycle", prev_wen, 0);
            check_eq("write_expected", n_writes <= n_pushed, 1);
            if (sb_q.size() != 0) begin
                exp_w = sb_q.pop_front();
                check_eq("w_addr", bus.IO_User_Mem_w_addr, exp_w[27:18]);
                check_eq("w_value", bus.IO_User_Mem_w_value, exp_w[17:0]);
            end
        end
        prev_wen <= bus.IO_User_Mem_w_en;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IO_SPI_cs   = 1'b1;
        bus.IO_SPI_sck  = 1'b0;
        bus.IO_SPI_mosi = 1'b0;
        rst_n = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        check_idle_outputs("reset");

        // Single write
        cs_low();
        check_eq("single_busy", busy, 1);
        send_bits(32'h01, 8);
        send_bits(32'h0005, 16);
        push_write(10'd5, 18'h0ABCD);
        send_bits(32'h00ABCD, 24);
        cs_high();
        check_eq("single_drained", sb_q.size(), 0);
        check_eq("single_writes", n_writes, 1);
        check_eq("single_frame_err", frame_err, 0);
        check_eq("single_busy_end", busy, 0);
        check_eq("hold_addr", bus.IO_User_Mem_w_addr, 5);
        check_eq("hold_value", bus.IO_User_Mem_w_value, 18'h0ABCD);

        // Burst crossing the address wrap
        cs_low();
        send_bits(32'h01, 8);
        send_bits(32'h03FE, 16);
        push_write(10'd1022, 18'd1);
        send_bits(32'd1, 24);
        push_write(10'd1023, 18'd2);
        send_bits(32'd2, 24);
        push_write(10'd0, 18'd3);
        send_bits(32'd3, 24);
        cs_high();
        check_eq("burst_drained", sb_q.size(), 0);
        check_eq("burst_writes", n_writes, 4);
        check_eq("burst_frame_err", frame_err, 0);

        // Bad command, then a good frame clears the error
        cs_low();
        send_bits(32'h7F, 8);
        send_bits(32'hDEADBEEF, 32);
        send_bits(32'hA5, 8);
        check_eq("badcmd_err", frame_err, 1);
        check_eq("badcmd_busy", busy, 1);
        cs_high();
        check_eq("badcmd_err_held", frame_err, 1);
        check_eq("badcmd_busy_end", busy, 0);
        check_eq("badcmd_writes", n_writes, 4);
        cs_low();
        check_eq("badcmd_err_cleared", frame_err, 0);
        send_bits(32'h01, 8);
        send_bits(32'h0155, 16);
        push_write(10'h155, 18'h3FFFF);
        send_bits(32'hFFFFFF, 24);
        cs_high();
        check_eq("recover_drained", sb_q.size(), 0);
        check_eq("recover_writes", n_writes, 5);
        check_eq("recover_frame_err", frame_err, 0);

        // Truncated data word
        cs_low();
        send_bits(32'h01, 8);
        send_bits(32'h0010, 16);
        send_bits(32'hABC, 12);
        cs_high();
        check_eq("trunc_err", frame_err, 1);
        check_eq("trunc_busy", busy, 0);
        check_eq("trunc_writes", n_writes, 5);

        // Reset in the middle of a data word
        cs_low();
        send_bits(32'h01, 8);
        send_bits(32'h0020, 16);
        send_bits(32'h12345, 20);
        rst_n = 1'b0;
        clks(1);
        rst_n = 1'b1;
        clks(1);
        check_idle_outputs("midreset");
        send_bits(32'h6, 4);
        send_bits(32'h000777, 24);
        clks(4);
        check_eq("midreset_busy_after", busy, 0);
        check_eq("midreset_writes", n_writes, 5);
        cs_high();
        check_eq("midreset_err_end", frame_err, 0);
        check_eq("midreset_busy_end", busy, 0);

`ifdef SPI_MISO_EN
        cs_low();
        send_bits(32'h01, 8);
        check_eq("miso_byte1", miso_cap, 8'h00);
        send_bits(32'h00, 8);
        check_eq("miso_byte2", miso_cap, 8'h01);
        send_bits(32'h20, 8);
        check_eq("miso_byte3", miso_cap, 8'h00);
        cs_high();
        check_eq("miso_idle", bus.IO_SPI_miso, 0);
`endif

        check_eq("final_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
